// File: rtl/rcv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | rcv_pkg: types and constants shared by the receive deframer and |
// | the receive controller.  Rev 1.0                                |
// +----------------------------------------------------------------+
package rcv_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    RECEIVE = 2'd1,
    END     = 2'd2
  } deframe_state_t;

  localparam logic [7:0] SFD_DEFAULT   = 8'hD0;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rcv_deframer_preamble_det.sv
`default_nettype none
// +----------------------------------------------------------------+
// | preamble_det: bit shift register, alternating-run counter and   |
// | SFD compare for the receive deframer.  Rev 1.0                  |
// +----------------------------------------------------------------+
module preamble_det
  import rcv_pkg::*;
#(
  parameter int          MIN_PRE_BITS = 16,
  parameter logic [7:0]  SFD          = SFD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hunt,
  input  logic       bit_in,
  input  logic       bit_strobe,
  input  logic       bit_err,
  input  logic       clear,
  output logic [7:0] shift_next,
  output logic       sfd_hit
);

  logic [7:0]      sr_q, sr_d;
  logic [7:0]      alt_ct_q, alt_ct_d;
  // hist_q[k] holds alt_ct as it was just before the strobe k+1 strobes ago
  logic [6:0][7:0] hist_q, hist_d;

  assign shift_next = {bit_in, sr_q[7:1]};

  always_comb begin
    sr_d     = sr_q;
    alt_ct_d = alt_ct_q;
    hist_d   = hist_q;
    if (clear) begin
      sr_d     = 8'd0;
      alt_ct_d = 8'd0;
      hist_d   = '0;
    end else begin
      if (bit_strobe) begin
        sr_d = shift_next;
      end
      if (hunt) begin
        if (bit_strobe) begin
          hist_d   = {hist_q[5:0], alt_ct_q};
          alt_ct_d = (bit_in != sr_q[7]) ? sat_inc8(alt_ct_q) : 8'd1;
        end
        if (bit_err) begin
          alt_ct_d = 8'd0;
        end
      end
    end
  end

  // hist_q[6] is the run length seen before the first of the eight SFD bits
  assign sfd_hit = hunt && bit_strobe && (shift_next == SFD) &&
                   (int'(hist_q[6]) >= MIN_PRE_BITS);

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q     <= 8'd0;
      alt_ct_q <= 8'd0;
      hist_q   <= '0;
    end else begin
      sr_q     <= sr_d;
      alt_ct_q <= alt_ct_d;
      hist_q   <= hist_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rcv_deframer.sv
`default_nettype none
// +----------------------------------------------------------------+
// | rcv_deframer: hunts preamble+SFD in the recovered bit stream    |
// | and assembles LSB-first frame bytes.  Rev 1.0                   |
// +----------------------------------------------------------------+
module rcv_deframer
  import rcv_pkg::*;
#(
  parameter int         MIN_PRE_BITS = 16,
  parameter logic [7:0] SFD          = 8'hD0,
  parameter int         IDLE_TIMEOUT = 64,
  parameter int         MAX_BYTES    = 288
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_strobe,
  input  logic       bit_err,
  output logic [7:0] data_rcvr,
  output logic       valid,
  output logic       cardet,
  output logic [8:0] byte_ct,
  output logic       trunc_err,
  output logic [7:0] frame_ct
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1) + 1;

  deframe_state_t    state_q, state_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              cardet_q, cardet_d;
  logic [8:0]        byte_ct_q, byte_ct_d;
  logic              trunc_q, trunc_d;
  logic [7:0]        frame_ct_q, frame_ct_d;
  logic [2:0]        bit_ct_q, bit_ct_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  logic       det_clear;
  logic       sfd_hit;
  logic [7:0] shift_next;

  preamble_det #(
    .MIN_PRE_BITS (MIN_PRE_BITS),
    .SFD          (SFD)
  ) u_preamble_det (
    .clk        (clk),
    .rst        (rst),
    .hunt       (state_q == HUNT),
    .bit_in     (bit_in),
    .bit_strobe (bit_strobe),
    .bit_err    (bit_err),
    .clear      (det_clear),
    .shift_next (shift_next),
    .sfd_hit    (sfd_hit)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    cardet_d   = cardet_q;
    byte_ct_d  = byte_ct_q;
    trunc_d    = 1'b0;
    frame_ct_d = frame_ct_q;
    bit_ct_d   = bit_ct_q;
    idle_d     = idle_q;
    det_clear  = 1'b0;
    case (state_q)
      HUNT: begin
        if (sfd_hit) begin
          state_d   = RECEIVE;
          cardet_d  = 1'b1;
          byte_ct_d = 9'd0;
          bit_ct_d  = 3'd0;
          idle_d    = '0;
        end
      end
      RECEIVE: begin
        // an error discards any bit strobed alongside it
        if (bit_err) begin
          state_d = END;
        end else begin
          if (bit_strobe) begin
            bit_ct_d = bit_ct_q + 3'd1;
            idle_d   = '0;
            if ((bit_ct_q == 3'd7) && (int'(byte_ct_q) < MAX_BYTES)) begin
              data_d    = shift_next;
              valid_d   = 1'b1;
              byte_ct_d = byte_ct_q + 9'd1;
            end
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
          if (idle_q == IDLE_W'(IDLE_TIMEOUT)) begin
            state_d = END;
          end
        end
      end
      END: begin
        state_d   = HUNT;
        cardet_d  = 1'b0;
        trunc_d   = (bit_ct_q != 3'd0);
        det_clear = 1'b1;
        bit_ct_d  = 3'd0;
        idle_d    = '0;
        if (byte_ct_q != 9'd0) begin
          frame_ct_d = frame_ct_q + 8'd1;
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      cardet_q   <= 1'b0;
      byte_ct_q  <= 9'd0;
      trunc_q    <= 1'b0;
      frame_ct_q <= 8'd0;
      bit_ct_q   <= 3'd0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      cardet_q   <= cardet_d;
      byte_ct_q  <= byte_ct_d;
      trunc_q    <= trunc_d;
      frame_ct_q <= frame_ct_d;
      bit_ct_q   <= bit_ct_d;
      idle_q     <= idle_d;
    end
  end

  assign data_rcvr = data_q;
  assign valid     = valid_q;
  assign cardet    = cardet_q;
  assign byte_ct   = byte_ct_q;
  assign trunc_err = trunc_q;
  assign frame_ct  = frame_ct_q;

endmodule
`default_nettype wire

// File: tb/tb_rcv_deframer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------+
// | tb_rcv_deframer: directed frames against a bit-level model of   |
// | the deframer.  Rev 1.0                                          |
// +----------------------------------------------------------------+
module tb_rcv_deframer;

  localparam int         MIN_PRE = 16;
  localparam logic [7:0] SFD_V   = 8'hD0;
  localparam int         TMO     = 64;
  localparam int         MAXB    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_strobe;
  logic       bit_err;
  logic [7:0] data_rcvr;
  logic       valid;
  logic       cardet;
  logic [8:0] byte_ct;
  logic       trunc_err;
  logic [7:0] frame_ct;

  rcv_deframer #(
    .MIN_PRE_BITS (MIN_PRE),
    .SFD          (SFD_V),
    .IDLE_TIMEOUT (TMO),
    .MAX_BYTES    (MAXB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_strobe (bit_strobe),
    .bit_err    (bit_err),
    .data_rcvr  (data_rcvr),
    .valid      (valid),
    .cardet     (cardet),
    .byte_ct    (byte_ct),
    .trunc_err  (trunc_err),
    .frame_ct   (frame_ct)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: expected registered outputs, updated from the inputs at each rising edge
  logic [7:0] m_data = 8'd0;
  logic       m_valid = 1'b0, m_cardet = 1'b0, m_trunc = 1'b0;
  int         m_byte_ct = 0, m_frame_ct = 0;
  logic [7:0] m_sr = 8'd0, m_fb = 8'd0;
  int         hunt_q[$];
  bit         in_frame = 1'b0, end_pend = 1'b0;
  int         f_bits = 0, idle = 0;

  // Alternating run length ending at the bit just before the last eight received bits
  function automatic int pre_run();
    int last;
    int r;
    last = hunt_q.size() - 9;
    if (last < 0) return 0;
    r = 1;
    for (int j = last; j > 0 && hunt_q[j] != hunt_q[j-1]; j--) r++;
    return (r > 255) ? 255 : r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_data = 8'd0; m_valid = 1'b0; m_cardet = 1'b0; m_trunc = 1'b0;
      m_byte_ct = 0; m_frame_ct = 0; m_sr = 8'd0; hunt_q.delete();
      in_frame = 1'b0; end_pend = 1'b0; f_bits = 0; idle = 0;
    end else begin
      m_valid = 1'b0;
      m_trunc = 1'b0;
      if (end_pend) begin
        end_pend = 1'b0;
        m_cardet = 1'b0;
        m_trunc  = (f_bits % 8) != 0;
        if (m_byte_ct != 0) m_frame_ct = (m_frame_ct + 1) % 256;
        m_sr = 8'd0;
        hunt_q.delete();
      end else if (in_frame) begin
        if (bit_err) begin
          in_frame = 1'b0;
          end_pend = 1'b1;
        end else begin
          bit tmo;
          tmo = (idle == TMO);
          if (bit_strobe) begin
            f_bits++;
            m_fb = {bit_in, m_fb[7:1]};
            idle = 0;
            if ((f_bits % 8) == 0 && m_byte_ct < MAXB) begin
              m_data  = m_fb;
              m_valid = 1'b1;
              m_byte_ct++;
            end
          end else begin
            idle++;
          end
          if (tmo) begin
            in_frame = 1'b0;
            end_pend = 1'b1;
          end
        end
      end else begin
        if (bit_strobe) begin
          m_sr = {bit_in, m_sr[7:1]};
          hunt_q.push_back(int'(bit_in));
          if (m_sr == SFD_V && pre_run() >= MIN_PRE) begin
            in_frame = 1'b1; m_cardet = 1'b1; m_byte_ct = 0; f_bits = 0; idle = 0;
          end
        end
        if (bit_err) hunt_q.delete();
      end
    end
  end

  // Per-cycle comparison and event bookkeeping for the literal checks
  bit         chk_en = 1'b0;
  int         vcnt = 0, tcnt = 0;
  int         vbytes[$];
  bit         cd_seen = 1'b0, trunc_at_fall = 1'b0;
  logic       prev_cardet = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("data_rcvr", 32'(data_rcvr), 32'(m_data));
      cmp("valid",     32'(valid),     32'(m_valid));
      cmp("cardet",    32'(cardet),    32'(m_cardet));
      cmp("byte_ct",   32'(byte_ct),   32'(m_byte_ct));
      cmp("trunc_err", 32'(trunc_err), 32'(m_trunc));
      cmp("frame_ct",  32'(frame_ct),  32'(m_frame_ct));
      if (valid === 1'b1) begin
        vcnt++;
        vbytes.push_back(int'(data_rcvr));
      end
      if (trunc_err === 1'b1) begin
        tcnt++;
        trunc_at_fall = (cardet === 1'b0) && (prev_cardet === 1'b1);
      end
      if (cardet === 1'b1) cd_seen = 1'b1;
      prev_cardet = cardet;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    bit_in = b; bit_strobe = 1'b1;
    tick();
    bit_strobe = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 0; i < 8; i++) send_bit(v[i], gap);
  endtask

  task automatic send_pre(input int n, input int gap);
    for (int i = 0; i < n; i++) send_bit((i % 2) == 0, gap);
  endtask

  task automatic send_err();
    bit_err = 1'b1;
    tick();
    bit_err = 1'b0;
  endtask

  task automatic clear_stats();
    vcnt = 0; tcnt = 0; vbytes.delete(); cd_seen = 1'b0; trunc_at_fall = 1'b0;
  endtask

  function automatic int vb(input int k);
    return (vbytes.size() > k) ? vbytes[k] : -1;
  endfunction

  initial begin
    logic [7:0] tail;
    rst = 1'b1; bit_in = 1'b0; bit_strobe = 1'b0; bit_err = 1'b0;
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    cmp("reset_cardet",   32'(cardet),    32'd0);
    cmp("reset_data",     32'(data_rcvr), 32'd0);
    cmp("reset_frame_ct", 32'(frame_ct),  32'd0);
    tick();

    // Frame of three bytes, back-to-back strobes, ended by a symbol error
    clear_stats();
    send_pre(16, 0);
    send_byte(SFD_V, 0);
    send_byte(8'h07, 0); send_byte(8'h2A, 0); send_byte(8'h31, 0);
    send_err();
    repeat (4) tick();
    cmp("t1_valid_count", 32'(vcnt), 32'd3);
    cmp("t1_byte0", 32'(vb(0)), 32'h07);
    cmp("t1_byte1", 32'(vb(1)), 32'h2A);
    cmp("t1_byte2", 32'(vb(2)), 32'h31);
    cmp("t1_byte_ct", 32'(byte_ct), 32'd3);
    cmp("t1_frame_ct", 32'(frame_ct), 32'd1);
    cmp("t1_trunc_count", 32'(tcnt), 32'd0);
    cmp("t1_cardet_low", 32'(cardet), 32'd0);

    // Short preamble: the SFD must be ignored
    clear_stats();
    send_pre(8, 1);
    send_byte(SFD_V, 1);
    repeat (4) tick();
    cmp("t2_cardet_seen", 32'(cd_seen), 32'd0);
    cmp("t2_valid_count", 32'(vcnt), 32'd0);
    send_err();
    tick();

    // Two bytes plus five stray bits, then line idle
    clear_stats();
    tail = 8'h15;
    send_pre(16, 1);
    send_byte(SFD_V, 1);
    send_byte(8'h5A, 1); send_byte(8'hC3, 1);
    for (int i = 0; i < 5; i++) send_bit(tail[i], 1);
    repeat (80) tick();
    cmp("t3_valid_count", 32'(vcnt), 32'd2);
    cmp("t3_byte0", 32'(vb(0)), 32'h5A);
    cmp("t3_byte1", 32'(vb(1)), 32'hC3);
    cmp("t3_trunc_count", 32'(tcnt), 32'd1);
    cmp("t3_trunc_at_fall", 32'(trunc_at_fall), 32'd1);
    cmp("t3_frame_ct", 32'(frame_ct), 32'd2);

    // Six bytes against a four-byte cap
    clear_stats();
    send_pre(16, 0);
    send_byte(SFD_V, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
    repeat (3) tick();
    cmp("t4_cardet_held", 32'(cardet), 32'd1);
    send_err();
    repeat (4) tick();
    cmp("t4_valid_count", 32'(vcnt), 32'd4);
    cmp("t4_byte3", 32'(vb(3)), 32'h44);
    cmp("t4_byte_ct", 32'(byte_ct), 32'd4);
    cmp("t4_frame_ct", 32'(frame_ct), 32'd3);
    cmp("t4_trunc_count", 32'(tcnt), 32'd0);

    // Error coincident with the 8th bit of byte 2
    clear_stats();
    tail = 8'h3C;
    send_pre(16, 1);
    send_byte(SFD_V, 1);
    send_byte(8'hA5, 1);
    for (int i = 0; i < 7; i++) send_bit(tail[i], 1);
    bit_in = tail[7]; bit_strobe = 1'b1; bit_err = 1'b1;
    tick();
    bit_strobe = 1'b0; bit_err = 1'b0;
    repeat (4) tick();
    cmp("t5_valid_count", 32'(vcnt), 32'd1);
    cmp("t5_byte0", 32'(vb(0)), 32'hA5);
    cmp("t5_trunc_count", 32'(tcnt), 32'd1);
    cmp("t5_frame_ct", 32'(frame_ct), 32'd4);

    // Reset in the middle of a byte, then a clean frame
    clear_stats();
    tail = 8'h96;
    send_pre(16, 0);
    send_byte(SFD_V, 0);
    send_byte(tail, 0);
    for (int i = 0; i < 3; i++) send_bit(tail[i], 0);
    rst = 1'b1;
    tick();
    cmp("t6_rst_cardet",   32'(cardet),    32'd0);
    cmp("t6_rst_byte_ct",  32'(byte_ct),   32'd0);
    cmp("t6_rst_valid",    32'(valid),     32'd0);
    cmp("t6_rst_trunc",    32'(trunc_err), 32'd0);
    cmp("t6_rst_frame_ct", 32'(frame_ct),  32'd0);
    rst = 1'b0;
    tick();
    clear_stats();
    send_pre(16, 1);
    send_byte(SFD_V, 1);
    send_byte(8'h3C, 0); send_byte(8'hE1, 0);
    send_err();
    repeat (4) tick();
    cmp("t6_valid_count", 32'(vcnt), 32'd2);
    cmp("t6_byte0", 32'(vb(0)), 32'h3C);
    cmp("t6_byte1", 32'(vb(1)), 32'hE1);
    cmp("t6_frame_ct", 32'(frame_ct), 32'd1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/rcv_deframer.md
# rcv_deframer

- Bit-to-byte deframer directly upstream of the receive controller.
- Consumes the recovered bit stream from the Manchester decoder and hunts for preamble plus start-frame delimiter (SFD).
- Assembles frame bytes LSB-first and presents them as `data_rcvr`, with a one-cycle `valid` per byte and a frame-long `cardet`.
- End of frame is detected by decoder symbol error or line-idle timeout. Any partial trailing byte is discarded.

## Interface
Parameters:
- MIN_PRE_BITS, 16: alternating bits required before the SFD is accepted
- SFD, 8'hD0: start-frame delimiter, compared LSB-first as received
- IDLE_TIMEOUT, 64: clk cycles without `bit_strobe` that end a frame
- MAX_BYTES, 288: byte cap per frame; bytes beyond it are not reported

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- bit_in  in  1  recovered data bit, valid when `bit_strobe`=1
- bit_strobe  in  1  one-cycle pulse per recovered bit
- bit_err  in  1  one-cycle pulse, invalid Manchester symbol (carrier lost)
- data_rcvr  out  8  last assembled byte; held until the next byte
- valid  out  1  one-cycle pulse, `data_rcvr` is new
- cardet  out  1  high from SFD accept to end of frame
- byte_ct  out  9  bytes reported in the current/last frame
- trunc_err  out  1  one-cycle pulse at end of frame if a partial byte (1–7 bits) was discarded
- frame_ct  out  8  completed frames since reset, wraps at 255→0

## Operation
- Reset values: `data_rcvr`=0, `valid`=0, `cardet`=0, `byte_ct`=0, `trunc_err`=0, `frame_ct`=0; state HUNT; shift register 0; counters 0.
- States are HUNT, RECEIVE and END.
- HUNT:
  - On each strobe, shift `bit_in` into an 8-bit register (new bit enters at bit 7, shifting right).
  - `alt_ct` increments when `bit_in` ≠ previous bit; otherwise it resets to 1. It saturates at 255.
  - When the register equals SFD and the `alt_ct` value from before the SFD's first bit is ≥ MIN_PRE_BITS: go to RECEIVE, raise `cardet`, clear `byte_ct` and the bit counter.
  - `bit_err` in HUNT clears `alt_ct`.
- RECEIVE:
  - Each strobe shifts the bit in and increments `bit_ct` (3 bits).
  - On the 8th bit: load `data_rcvr`, pulse `valid`, increment `byte_ct`. Both of these happen only if `byte_ct` < MAX_BYTES; past the cap, bits are still consumed but nothing is reported.
  - On `bit_err`, or on the idle counter reaching IDLE_TIMEOUT, go to END.
  - The idle counter clears on every strobe.
- END (one cycle): `cardet`=0; pulse `trunc_err` if `bit_ct`≠0; increment `frame_ct` if `byte_ct`≠0; clear `alt_ct` and the shift register; go to HUNT.
- Simultaneous `bit_strobe` and `bit_err` in RECEIVE: the error wins, the bit is discarded and the transition to END is taken.
- A strobe that completes byte 8 in the same cycle as the idle timeout: the byte is reported, then END.

## Timing
- `valid` and the new `data_rcvr` are registered: they appear the cycle after the 8th strobe of a byte.
- `cardet` rises the cycle after the strobe that completes the SFD. It falls the cycle after the `bit_err`/timeout cycle (END) and is low for ≥1 cycle between frames.
- The first byte after the SFD therefore always arrives while `cardet`=1; no `valid` occurs while `cardet`=0.
- The last byte's `valid` precedes the `cardet` fall by ≥1 cycle.
- `trunc_err` and the `frame_ct` update coincide with the first cycle of `cardet`=0.
- Reset mid-frame: the next cycle shows all outputs at reset values, with no `valid` or `trunc_err` pulse.
- The block accepts a strobe on any cycle, including back-to-back, with no stall or backpressure.

## Structure
- Package `rcv_pkg`: state enum `deframe_state_t` {HUNT, RECEIVE, END}, default SFD constant 8'hD0, preamble byte 8'h55. The receive controller shares this package.
- Sub-module `preamble_det`: owns the shift register, `alt_ct` and the SFD compare, and outputs a one-cycle `sfd_hit`. The FSM, byte/bit/idle counters and output registers live in the top.

## Test plan
- Preamble 2×8'h55 (16 alternating bits), SFD 8'hD0, bytes 8'h07, 8'h2A, 8'h31, then `bit_err`: exactly 3 `valid` pulses with data 07, 2A, 31; `byte_ct`=3; `cardet` low 1 cycle after the error; `frame_ct`=1; no `trunc_err`.
- Only 8 alternating bits, then SFD: `cardet` stays 0 and no `valid` occurs.
- Frame of 2 bytes plus 5 extra bits, then no strobes for 64 cycles: 2 `valid` pulses; `trunc_err` pulses once, coincident with the `cardet` fall.
- MAX_BYTES=4 with 6 bytes sent: 4 `valid` pulses; `byte_ct`=4; `cardet` held until `bit_err`.
- Strobe and `bit_err` in the same cycle on the 8th bit of byte 2: only byte 1 is reported, followed by `trunc_err`.
- `rst` asserted mid-byte in RECEIVE: the next cycle has `cardet`=0, `byte_ct`=0; a following clean frame is received correctly.
